io_responder: RTL and testbench

Memory-mapped bus responder on the far side of the CPU datapath's `addresses` / `data_inout` interface. It decodes CPU loads and stores into:
- a 256x16 data RAM,
- a 16-bit programmable down-counter timer,
- a 16-bit output port and a synchronised 16-bit input port.

It also raises level interrupt requests toward the interrupt manager's `int_e` inputs and holds them until acknowledged.

---
 rtl/io_responder_pkg.sv | 67 ++++++
 rtl/io_responder_timer16.sv | 59 +++++
 rtl/io_responder.sv | 141 ++++++++++++++
 tb/tb_io_responder.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
// Shared address map, register bit positions and IRQ line numbers for the
// io_responder bus slave and the CPU control unit that talks to it.
package io_responder_pkg;

  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] RAM_LIMIT   = 16'h00FF;
  localparam logic [15:0] IO_TCOUNT   = 16'hFF00;
  localparam logic [15:0] IO_TRELOAD  = 16'hFF01;
  localparam logic [15:0] IO_TCTRL    = 16'hFF02;
  localparam logic [15:0] IO_STATUS   = 16'hFF03;
  localparam logic [15:0] IO_PORT_OUT = 16'hFF04;
  localparam logic [15:0] IO_PORT_IN  = 16'hFF05;
  localparam logic [15:0] IO_PEND     = 16'hFF06;
  localparam logic [15:0] IO_PIE      = 16'hFF07;

  localparam int TCTRL_EN     = 0;
  localparam int TCTRL_AUTO   = 1;
  localparam int TCTRL_TIE    = 2;
  localparam int STATUS_TEXP  = 0;
  localparam int STATUS_PEDGE = 1;
  localparam int IRQ_TIMER    = 0;
  localparam int IRQ_PORT     = 1;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TCOUNT,
    SEL_TRELOAD,
    SEL_TCTRL,
    SEL_STATUS,
    SEL_PORT_OUT,
    SEL_PORT_IN,
    SEL_PEND,
    SEL_PIE
  } io_sel_e;

  typedef struct packed {
    logic tie;
    logic auto_rl;
    logic en;
  } tctrl_t;

  // RAM occupies the bottom window, trimmed further when the RAM is smaller.
  function automatic io_sel_e io_decode(input logic [15:0] addr,
                                        input int unsigned ram_words);
    io_sel_e sel;
    sel = SEL_NONE;
    if (((addr - RAM_BASE) <= (RAM_LIMIT - RAM_BASE)) &&
        (32'(addr - RAM_BASE) < ram_words)) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        IO_TCOUNT:   sel = SEL_TCOUNT;
        IO_TRELOAD:  sel = SEL_TRELOAD;
        IO_TCTRL:    sel = SEL_TCTRL;
        IO_STATUS:   sel = SEL_STATUS;
        IO_PORT_OUT: sel = SEL_PORT_OUT;
        IO_PORT_IN:  sel = SEL_PORT_IN;
        IO_PEND:     sel = SEL_PEND;
        IO_PIE:      sel = SEL_PIE;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/io_responder_timer16.sv
// 16-bit programmable down-counter: TCOUNT, TRELOAD, TCTRL and a
// combinational expiry pulse asserted while TCOUNT is 0 with EN set.
module timer16
  import io_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_reload,
  input  logic        i_wr_ctrl,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_tcount,
  output logic [15:0] o_treload,
  output tctrl_t      o_tctrl,
  output logic        o_expire
);

  logic [15:0] r_count;
  logic [15:0] r_reload;
  tctrl_t      r_ctrl;
  logic        w_expire;

  assign w_expire = r_ctrl.en & (r_count == 16'd0);

  // NOTE: sequential state uses <= so every flop samples pre-edge values
  // regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_reload <= '0;
      r_ctrl   <= '0;
    end else begin
      // A reload write restarts the count and overrides the decrement.
      if (i_wr_reload) begin
        r_count  <= i_wdata;
        r_reload <= i_wdata;
      end else if (r_ctrl.en) begin
        if (r_count != 16'd0) begin
          r_count <= r_count - 16'd1;
        end else if (r_ctrl.auto_rl) begin
          r_count <= r_reload;
        end
      end

      if (i_wr_ctrl) begin
        r_ctrl.en      <= i_wdata[TCTRL_EN];
        r_ctrl.auto_rl <= i_wdata[TCTRL_AUTO];
        r_ctrl.tie     <= i_wdata[TCTRL_TIE];
      end else if (w_expire && !r_ctrl.auto_rl) begin
        r_ctrl.en <= 1'b0;
      end
    end
  end

  assign o_tcount  = r_count;
  assign o_treload = r_reload;
  assign o_tctrl   = r_ctrl;
  assign o_expire  = w_expire;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped responder: address decode, data RAM, timer, I/O ports,
// sticky status, pending interrupt requests and the shared-bus driver.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int RAM_AW = 8,
  parameter int IRQ_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      addresses,
  inout  wire  [15:0]      data_inout,
  input  logic             oe,
  input  logic             cpu_we,
  input  logic             cpu_re,
  input  logic [15:0]      port_in,
  output logic [15:0]      port_out,
  input  logic [IRQ_W-1:0] int_ack,
  output logic [IRQ_W-1:0] int_req
);

  localparam int unsigned RAM_WORDS = 1 << RAM_AW;

  io_sel_e     w_sel;
  logic [15:0] w_wdata;
  logic [15:0] w_rdata;
  logic        w_drive;
  logic        w_wr_ram, w_wr_reload, w_wr_ctrl, w_wr_status;
  logic        w_wr_port_out, w_wr_pie;

  logic [15:0] w_tcount, w_treload;
  tctrl_t      w_tctrl;
  logic        w_expire;

  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_sync1, r_sync2;
  logic        r_prev0;
  logic        w_port_edge;
  logic [15:0] r_port_out;
  logic        r_pie;
  logic        r_texp, r_pedge;
  logic        r_irq_timer, r_irq_port;
  logic        w_unused_ack;

  assign w_sel   = io_decode(addresses, RAM_WORDS);
  assign w_wdata = data_inout;

  assign w_wr_ram      = cpu_we & (w_sel == SEL_RAM);
  assign w_wr_reload   = cpu_we & (w_sel == SEL_TRELOAD);
  assign w_wr_ctrl     = cpu_we & (w_sel == SEL_TCTRL);
  assign w_wr_status   = cpu_we & (w_sel == SEL_STATUS);
  assign w_wr_port_out = cpu_we & (w_sel == SEL_PORT_OUT);
  assign w_wr_pie      = cpu_we & (w_sel == SEL_PIE);

  timer16 u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_wr_reload (w_wr_reload),
    .i_wr_ctrl   (w_wr_ctrl),
    .i_wdata     (w_wdata),
    .o_tcount    (w_tcount),
    .o_treload   (w_treload),
    .o_tctrl     (w_tctrl),
    .o_expire    (w_expire)
  );

  // NOTE: the RAM deliberately has no reset branch; contents survive reset
  // and the array stays mappable onto a RAM macro.
  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      r_ram[addresses[RAM_AW-1:0]] <= w_wdata;
    end
  end

  // Two-flop synchroniser plus one history bit for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev0 <= 1'b0;
    end else begin
      r_sync1 <= port_in;
      r_sync2 <= r_sync1;
      r_prev0 <= r_sync2[0];
    end
  end

  assign w_port_edge = r_sync2[0] & ~r_prev0;

  // Sticky and pending bits: a set event in the same cycle beats any clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_port_out  <= '0;
      r_pie       <= 1'b0;
      r_texp      <= 1'b0;
      r_pedge     <= 1'b0;
      r_irq_timer <= 1'b0;
      r_irq_port  <= 1'b0;
    end else begin
      if (w_wr_port_out) r_port_out <= w_wdata;
      if (w_wr_pie)      r_pie      <= w_wdata[0];
      r_texp      <= w_expire    | (r_texp  & ~(w_wr_status & w_wdata[STATUS_TEXP]));
      r_pedge     <= w_port_edge | (r_pedge & ~(w_wr_status & w_wdata[STATUS_PEDGE]));
      r_irq_timer <= (w_expire & w_tctrl.tie) | (r_irq_timer & ~int_ack[IRQ_TIMER]);
      r_irq_port  <= (w_port_edge & r_pie)    | (r_irq_port  & ~int_ack[IRQ_PORT]);
    end
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_RAM:      w_rdata = r_ram[addresses[RAM_AW-1:0]];
      SEL_TCOUNT:   w_rdata = w_tcount;
      SEL_TRELOAD:  w_rdata = w_treload;
      SEL_TCTRL:    w_rdata = 16'(w_tctrl);
      SEL_STATUS:   w_rdata = 16'({r_pedge, r_texp});
      SEL_PORT_OUT: w_rdata = r_port_out;
      SEL_PORT_IN:  w_rdata = r_sync2;
      SEL_PEND:     w_rdata = 16'({r_irq_port, r_irq_timer});
      SEL_PIE:      w_rdata = 16'(r_pie);
      default:      w_rdata = '0;
    endcase
  end

  always_comb begin
    int_req            = '0;
    int_req[IRQ_TIMER] = r_irq_timer;
    int_req[IRQ_PORT]  = r_irq_port;
  end

  // Only a pure load drives the bus; a store always owns it.
  assign w_drive    = cpu_re & ~oe & ~cpu_we;
  assign data_inout = w_drive ? w_rdata : 16'hzzzz;
  assign port_out   = r_port_out;

  // Acks for lines that never request are accepted and ignored.
  assign w_unused_ack = ^int_ack[IRQ_W-1:2];

endmodule

// File: tb/tb_io_responder.sv
// Randomised self-checking bench for io_responder against a cycle-level
// behavioural model of the register map, timer, port and interrupt rules.
module tb_io_responder;
  import io_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addresses;
  logic        oe, cpu_we, cpu_re;
  logic [15:0] port_in;
  logic [15:0] port_out;
  logic [7:0]  int_ack;
  logic [7:0]  int_req;
  wire  [15:0] data_inout;
  logic        tb_drive;
  logic [15:0] tb_wdata;

  int n_vec = 0;
  int n_err = 0;

  assign data_inout = tb_drive ? tb_wdata : 16'hzzzz;

  always #5 clk = ~clk;

  io_responder #(.RAM_AW(8), .IRQ_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .addresses  (addresses),
    .data_inout (data_inout),
    .oe         (oe),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .port_in    (port_in),
    .port_out   (port_out),
    .int_ack    (int_ack),
    .int_req    (int_req)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_ram [256];
  bit          m_ram_v [256];
  logic [15:0] m_tcount, m_treload, m_pout;
  logic        m_en, m_auto, m_tie, m_texp, m_pedge, m_pie;
  logic [1:0]  m_pend;
  logic [15:0] ph[$];  // port_in sampled at each clock, newest last

  task automatic m_reset();
    m_tcount = 0; m_treload = 0; m_pout = 0;
    m_en = 0; m_auto = 0; m_tie = 0; m_texp = 0; m_pedge = 0; m_pie = 0;
    m_pend = 0;
    ph.delete();
    repeat (3) ph.push_back(16'h0000);
  endtask

  function automatic logic m_edge_now();
    return ph[$-1][0] && !ph[$-2][0];
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a <= RAM_LIMIT) return m_ram[a[7:0]];
    case (a)
      IO_TCOUNT:   return m_tcount;
      IO_TRELOAD:  return m_treload;
      IO_TCTRL:    return {13'b0, m_tie, m_auto, m_en};
      IO_STATUS:   return {14'b0, m_pedge, m_texp};
      IO_PORT_OUT: return m_pout;
      IO_PORT_IN:  return ph[$-1];
      IO_PEND:     return {14'b0, m_pend};
      IO_PIE:      return {15'b0, m_pie};
      default:     return 16'h0000;
    endcase
  endfunction

  // Advance the model by one clock using the inputs present this cycle.
  task automatic m_step();
    logic expire, pin_edge, wr, old_tie, old_auto, old_pie;
    logic [15:0] a, d;
    if (reset) begin
      m_reset();
      return;
    end
    expire   = m_en && (m_tcount == 0);
    pin_edge = m_edge_now();
    wr = cpu_we; a = addresses; d = tb_wdata;
    old_tie = m_tie; old_auto = m_auto; old_pie = m_pie;
    if (wr && a == IO_TRELOAD) begin
      m_tcount = d; m_treload = d;
    end else if (m_en) begin
      if (m_tcount != 0) m_tcount = m_tcount - 1;
      else if (old_auto) m_tcount = m_treload;
    end
    if (wr && a == IO_TCTRL) begin
      m_en = d[TCTRL_EN]; m_auto = d[TCTRL_AUTO]; m_tie = d[TCTRL_TIE];
    end else if (expire && !old_auto) begin
      m_en = 0;
    end
    m_texp  = expire   || (m_texp  && !(wr && a == IO_STATUS && d[0]));
    m_pedge = pin_edge || (m_pedge && !(wr && a == IO_STATUS && d[1]));
    m_pend[0] = (expire && old_tie)   || (m_pend[0] && !int_ack[0]);
    m_pend[1] = (pin_edge && old_pie) || (m_pend[1] && !int_ack[1]);
    if (wr && a == IO_PORT_OUT) m_pout = d;
    if (wr && a == IO_PIE) m_pie = d[0];
    if (wr && a <= RAM_LIMIT) begin
      m_ram[a[7:0]] = d; m_ram_v[a[7:0]] = 1'b1;
    end
    ph.push_back(port_in);
    if (ph.size() > 3) void'(ph.pop_front());
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    m_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cpu_we = 0; cpu_re = 0; oe = 0; tb_drive = 0; int_ack = 0;
    addresses = 16'h0000; tb_wdata = 16'h0000;
  endtask

  task automatic bus_store(input logic [15:0] a, input logic [15:0] d);
    addresses = a; cpu_we = 1; cpu_re = 0; oe = 1; tb_drive = 1; tb_wdata = d;
    tick();
    idle();
  endtask

  task automatic bus_load(input logic [15:0] a, output logic [15:0] v);
    addresses = a; cpu_re = 1; cpu_we = 0; oe = 0; tb_drive = 0;
    #1;
    v = data_inout;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] v;
    reset = 1; port_in = 0; idle();
    tick(); tick();
    reset = 0;
    n_vec++;
    if (port_out !== 16'h0000) begin
      n_err++; $display("FAIL reset_port_out: got %h expected 0000", port_out);
    end
    n_vec++;
    if (int_req !== 8'h00) begin
      n_err++; $display("FAIL reset_int_req: got %h expected 00", int_req);
    end
    for (int i = 0; i < 8; i++) begin
      bus_load(IO_TCOUNT + 16'(i), v);
      n_vec++;
      if (v !== 16'h0000) begin
        n_err++; $display("FAIL reset_reg_%0d: got %h expected 0000", i, v);
      end
    end
    idle();
  endtask

  task automatic test_ram();
    logic [15:0] v, a, d;
    logic [15:0] addrs[$];
    bus_store(16'h0010, 16'hBEEF);
    bus_load(16'h0010, v);
    n_vec++;
    if (v !== 16'hBEEF) begin
      n_err++; $display("FAIL ram_beef: got %h expected beef", v);
    end
    tick(); idle();
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom_range(32, 255));
      d = 16'($urandom);
      bus_store(a, d);
      addrs.push_back(a);
    end
    foreach (addrs[i]) begin
      bus_load(addrs[i], v);
      n_vec++;
      if (v !== m_read(addrs[i])) begin
        n_err++; $display("FAIL ram_rand @%h: got %h expected %h", addrs[i], v, m_read(addrs[i]));
      end
      tick(); idle();
    end
    foreach (addrs[i]) begin end
    begin
      logic [15:0] unm [3];
      unm[0] = 16'h0200; unm[1] = 16'h1234; unm[2] = 16'hFF08;
      for (int i = 0; i < 3; i++) begin
        bus_load(unm[i], v);
        n_vec++;
        if (v !== 16'h0000) begin
          n_err++; $display("FAIL unmapped @%h: got %h expected 0000", unm[i], v);
        end
      end
    end
    idle();
    // oe high: the responder must stay off the bus.
    bus_store(IO_PORT_OUT, 16'h5A5A);
    addresses = IO_PORT_OUT; cpu_re = 1; oe = 1; tb_drive = 0;
    #1;
    n_vec++;
    if (data_inout === 16'h5A5A) begin
      n_err++; $display("FAIL oe_no_drive: got %h expected undriven", data_inout);
    end
    n_vec++;
    if (port_out !== 16'h5A5A) begin
      n_err++; $display("FAIL port_out: got %h expected 5a5a", port_out);
    end
    // Simultaneous store and load: the write happens, the bus is the CPU's.
    addresses = 16'h0020; cpu_we = 1; cpu_re = 1; oe = 0; tb_drive = 1; tb_wdata = 16'hC0DE;
    #1;
    n_vec++;
    if (data_inout !== 16'hC0DE) begin
      n_err++; $display("FAIL we_re_bus: got %h expected c0de", data_inout);
    end
    tick(); idle();
    bus_load(16'h0020, v);
    n_vec++;
    if (v !== 16'hC0DE) begin
      n_err++; $display("FAIL we_re_write: got %h expected c0de", v);
    end
    idle();
  endtask

  task automatic test_timer_auto();
    logic [15:0] v;
    bus_store(IO_TRELOAD, 16'd3);
    bus_store(IO_TCTRL, 16'h0007);
    for (int c = 0; c < 13; c++) begin
      bus_load(IO_TCOUNT, v);
      n_vec++;
      if (v !== m_read(IO_TCOUNT)) begin
        n_err++; $display("FAIL tauto_count c%0d: got %h expected %h", c, v, m_read(IO_TCOUNT));
      end
      n_vec++;
      if (int_req !== {6'b0, m_pend}) begin
        n_err++; $display("FAIL tauto_irq c%0d: got %h expected %h", c, int_req, {6'b0, m_pend});
      end
      if (c == 0 || c == 4) begin
        n_vec++;
        if (v !== 16'd3) begin
          n_err++; $display("FAIL tauto_reload c%0d: got %h expected 0003", c, v);
        end
      end
      if (c == 4) begin
        n_vec++;
        if (int_req[0] !== 1'b1) begin
          n_err++; $display("FAIL tauto_irq0_rise: got %b expected 1", int_req[0]);
        end
      end
      tick();
    end
    bus_load(IO_STATUS, v);
    n_vec++;
    if (v !== m_read(IO_STATUS)) begin
      n_err++; $display("FAIL tauto_status: got %h expected %h", v, m_read(IO_STATUS));
    end
    idle();
    bus_store(IO_TCTRL, 16'h0000);
    int_ack = 8'h01;
    bus_store(IO_STATUS, 16'h0003);
    int_ack = 8'h01;
    bus_store(IO_STATUS, 16'h0003);
    n_vec++;
    if (int_req !== 8'h00) begin
      n_err++; $display("FAIL tauto_ack: got %h expected 00", int_req);
    end
  endtask

  task automatic test_timer_oneshot();
    logic [15:0] v;
    bus_store(IO_TRELOAD, 16'd2);
    bus_store(IO_TCTRL, 16'h0001);
    for (int c = 0; c < 6; c++) begin
      bus_load(IO_TCOUNT, v);
      n_vec++;
      if (v !== m_read(IO_TCOUNT)) begin
        n_err++; $display("FAIL tone_count c%0d: got %h expected %h", c, v, m_read(IO_TCOUNT));
      end
      tick();
    end
    bus_load(IO_TCTRL, v);
    n_vec++;
    if (v !== 16'h0000) begin
      n_err++; $display("FAIL tone_ctrl: got %h expected 0000", v);
    end
    bus_load(IO_STATUS, v);
    n_vec++;
    if (v !== 16'h0001) begin
      n_err++; $display("FAIL tone_texp: got %h expected 0001", v);
    end
    n_vec++;
    if (int_req[0] !== 1'b0) begin
      n_err++; $display("FAIL tone_no_irq: got %b expected 0", int_req[0]);
    end
    idle();
  endtask

  task automatic port_cycle(input string tag, input int c);
    logic [15:0] v;
    bus_load(IO_PORT_IN, v);
    n_vec++;
    if (v !== m_read(IO_PORT_IN)) begin
      n_err++; $display("FAIL %s_portin c%0d: got %h expected %h", tag, c, v, m_read(IO_PORT_IN));
    end
    n_vec++;
    if (int_req !== {6'b0, m_pend}) begin
      n_err++; $display("FAIL %s_irq c%0d: got %h expected %h", tag, c, int_req, {6'b0, m_pend});
    end
  endtask

  task automatic test_port();
    int waited;
    bus_store(IO_PIE, 16'h0001);
    port_in = 16'($urandom) & 16'hFFFE;
    repeat (3) tick();
    port_in = 16'($urandom) | 16'h0001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      port_cycle("edge", c);
      if (c == 2) begin
        n_vec++;
        if (int_req[1] !== 1'b0) begin
          n_err++; $display("FAIL edge_early: got %b expected 0", int_req[1]);
        end
      end
    end
    n_vec++;
    if (int_req[1] !== 1'b1) begin
      n_err++; $display("FAIL edge_3cyc: got %b expected 1", int_req[1]);
    end
    idle();
    int_ack = 8'h02;
    tick();
    int_ack = 8'h00;
    port_cycle("ack", 0);
    n_vec++;
    if (int_req[1] !== 1'b0) begin
      n_err++; $display("FAIL ack_clear: got %b expected 0", int_req[1]);
    end
    // Two more rising edges; the second coincides with an acknowledge.
    for (int k = 0; k < 2; k++) begin
      port_in[0] = 1'b0;
      repeat (3) tick();
      port_in[0] = 1'b1;
      waited = 0;
      while (!m_edge_now() && waited < 6) begin
        tick(); waited++;
      end
      n_vec++;
      if (!m_edge_now()) begin
        n_err++; $display("FAIL edge_wait: got timeout expected edge");
      end
      if (k == 1) int_ack = 8'h02;
      tick();
      int_ack = 8'h00;
      port_cycle("ack_edge", k);
    end
    n_vec++;
    if (int_req[1] !== 1'b1) begin
      n_err++; $display("FAIL set_beats_ack: got %b expected 1", int_req[1]);
    end
    idle();
  endtask

  task automatic test_random();
    logic [15:0] v, a, d;
    int op, sel;
    for (int c = 0; c < 300; c++) begin
      idle();
      op  = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = IO_TCOUNT + 16'(sel);
      else if (sel == 8) a = 16'($urandom_range(32, 255));
      else               a = 16'($urandom);
      d = 16'($urandom);
      if (a == IO_TRELOAD) d = d & 16'h000F;
      if ($urandom_range(0, 3) == 0) int_ack = 8'($urandom);
      if ($urandom_range(0, 4) == 0) port_in = 16'($urandom);
      addresses = a;
      if (op >= 2) begin
        cpu_we = 1; oe = 1; tb_drive = 1; tb_wdata = d;
      end
      if (op == 1 || op == 3) cpu_re = 1;
      #1;
      if (op == 1 && (a > RAM_LIMIT || m_ram_v[a[7:0]])) begin
        v = data_inout;
        n_vec++;
        if (v !== m_read(a)) begin
          n_err++; $display("FAIL rand_load c%0d @%h: got %h expected %h", c, a, v, m_read(a));
        end
      end
      if (op == 3) begin
        n_vec++;
        if (data_inout !== d) begin
          n_err++; $display("FAIL rand_we_re c%0d: got %h expected %h", c, data_inout, d);
        end
      end
      n_vec++;
      if (port_out !== m_pout || int_req !== {6'b0, m_pend}) begin
        n_err++;
        $display("FAIL rand_outs c%0d: got %h/%h expected %h/%h", c, port_out, int_req, m_pout, {6'b0, m_pend});
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    int waited;
    bus_store(16'h0010, 16'hBEEF);
    bus_store(IO_TCTRL, 16'h0000);
    bus_store(IO_TRELOAD, 16'd9);
    bus_store(IO_PORT_OUT, 16'h1234);
    bus_store(IO_TCTRL, 16'h0001);
    waited = 0;
    while (m_tcount != 16'd5 && waited < 20) begin
      tick(); waited++;
    end
    bus_load(IO_TCOUNT, v);
    n_vec++;
    if (v !== 16'd5) begin
      n_err++; $display("FAIL rmid_pre: got %h expected 0005", v);
    end
    idle();
    reset = 1;
    tick();
    reset = 0;
    bus_load(IO_TCOUNT, v);
    n_vec++;
    if (v !== 16'h0000) begin
      n_err++; $display("FAIL rmid_tcount: got %h expected 0000", v);
    end
    bus_load(IO_TCTRL, v);
    n_vec++;
    if (v !== 16'h0000) begin
      n_err++; $display("FAIL rmid_tctrl: got %h expected 0000", v);
    end
    n_vec++;
    if (int_req !== 8'h00 || port_out !== 16'h0000) begin
      n_err++; $display("FAIL rmid_outs: got %h/%h expected 00/0000", int_req, port_out);
    end
    bus_load(16'h0010, v);
    n_vec++;
    if (v !== 16'hBEEF) begin
      n_err++; $display("FAIL rmid_ram: got %h expected beef", v);
    end
    tick();
    bus_load(IO_TCOUNT, v);
    n_vec++;
    if (v !== 16'h0000) begin
      n_err++; $display("FAIL rmid_hold: got %h expected 0000", v);
    end
    idle();
  endtask

  initial begin
    reset = 1; port_in = 0;
    idle();
    m_reset();
    foreach (m_ram_v[i]) m_ram_v[i] = 1'b0;
    test_reset();
    test_ram();
    test_timer_auto();
    test_timer_oneshot();
    test_port();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
